// File: rtl/clk_buf_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_buf_gate_ctrl
//   Drives the enable of a gated clock-buffer primitive shared by N_REQ
//   requesters. A request turns the buffer on, waits WAKE_CYCLES for the
//   buffered clock to settle, then grants. Once every request has dropped the
//   buffer is held on for IDLE_CYCLES of hysteresis before being switched off.
//
// Parameters
//   N_REQ        number of requesters (1..16)
//   WAKE_CYCLES  cycles from gate_en rise to first ack (>=1)
//   IDLE_CYCLES  request-free cycles before gate_en falls (>=1)
//
// Ports
//   clock_input  in   free-running controller clock, rising edge
//   reset_n      in   asynchronous assert, active-low reset
//   force_on     in   (only with CLK_BUF_GATE_FORCE_ON_EN) keep buffer enabled
//   req          in   [N_REQ] per-requester clock request, level
//   ack          out  [N_REQ] per-requester grant, buffered clock running
//   gate_en      out  registered enable to the clock-buffer primitive
//   clk_active   out  high while in ON or IDLE_WAIT
//   state_o      out  [2] OFF=0, WAKE=1, ON=2, IDLE_WAIT=3
//
// Configuration macro
//   CLK_BUF_GATE_FORCE_ON_EN  adds force_on, an always-set virtual request
//                             that never produces an ack.
// -----------------------------------------------------------------------------
module clk_buf_gate_ctrl #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned WAKE_CYCLES = 4,
   parameter int unsigned IDLE_CYCLES = 8
) (
   input  logic             clock_input,
   input  logic             reset_n,
`ifdef CLK_BUF_GATE_FORCE_ON_EN
   input  logic             force_on,
`endif
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] ack,
   output logic             gate_en,
   output logic             clk_active,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_IDLE = 2'd3
   } state_t;

   localparam int unsigned CNT_MAX = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N_REQ-1:0] ack_nxt;
   logic             any_req;

`ifdef CLK_BUF_GATE_FORCE_ON_EN
   assign any_req = (|req) | force_on;
`else
   assign any_req = |req;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ack_nxt   = '0;
      unique case (state)
         ST_OFF: begin
            if (any_req) begin
               state_nxt = ST_WAKE;
               cnt_nxt   = WAKE_LOAD;
            end
         end
         ST_WAKE: begin
            // Wake always runs to completion; the grant is registered on the
            // same edge that enters ON so the first ack lands exactly
            // WAKE_CYCLES after gate_en rose.
            if (cnt == '0) begin
               state_nxt = ST_ON;
               ack_nxt   = req;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_ON: begin
            ack_nxt = req;
            if (!any_req) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = IDLE_LOAD;
            end
         end
         ST_IDLE: begin
            // A request wins over idle expiry: returns to ON with no re-wake,
            // ack follows one cycle later from the ON state.
            if (any_req) begin
               state_nxt = ST_ON;
            end else if (cnt == '0) begin
               state_nxt = ST_OFF;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock_input or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_OFF;
         cnt        <= '0;
         ack        <= '0;
         gate_en    <= 1'b0;
         clk_active <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ack        <= ack_nxt;
         gate_en    <= (state_nxt != ST_OFF);
         clk_active <= (state_nxt == ST_ON) || (state_nxt == ST_IDLE);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_clk_buf_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_buf_gate_ctrl
//   Table-driven bench for clk_buf_gate_ctrl at default parameters. Each table
//   row is the req value driven for one cycle and the outputs required after
//   the following rising edge; rows go through a scoreboard queue. Reset
//   corner cases (and force_on, when the macro is defined) are hand-written.
// -----------------------------------------------------------------------------
module tb_clk_buf_gate_ctrl;

   typedef struct {
      logic [3:0] req;
      logic       gate;
      logic [3:0] ack;
      logic [1:0] st;
   } vec_t;

   logic       clock_input = 1'b0;
   logic       reset_n     = 1'b0;
   logic [3:0] req         = 4'h0;
   logic [3:0] ack;
   logic       gate_en;
   logic       clk_active;
   logic [1:0] state_o;
`ifdef CLK_BUF_GATE_FORCE_ON_EN
   logic       force_on    = 1'b0;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   vec_t tbl[$];
   vec_t sb[$];

   clk_buf_gate_ctrl #(
      .N_REQ       (4),
      .WAKE_CYCLES (4),
      .IDLE_CYCLES (8)
   ) dut (
      .clock_input (clock_input),
      .reset_n     (reset_n),
`ifdef CLK_BUF_GATE_FORCE_ON_EN
      .force_on    (force_on),
`endif
      .req         (req),
      .ack         (ack),
      .gate_en     (gate_en),
      .clk_active  (clk_active),
      .state_o     (state_o)
   );

   always #5 clock_input = ~clock_input;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic g, input logic [3:0] a,
                            input logic [1:0] s, input logic act);
      check({tag, ".gate_en"},    {31'd0, gate_en},    {31'd0, g});
      check({tag, ".ack"},        {28'd0, ack},        {28'd0, a});
      check({tag, ".state_o"},    {30'd0, state_o},    {30'd0, s});
      check({tag, ".clk_active"}, {31'd0, clk_active}, {31'd0, act});
   endtask

   task automatic add(input logic [3:0] r, input logic g, input logic [3:0] a,
                      input logic [1:0] s, input int unsigned n);
      vec_t v;
      v.req = r; v.gate = g; v.ack = a; v.st = s;
      for (int unsigned i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      vec_t e;

      // Reset held with all requests up: everything stays off.
      req = 4'hF;
      repeat (3) @(negedge clock_input);
      check_all("reset_hold", 1'b0, 4'h0, 2'd0, 1'b0);

      // Release, then 4 WAKE cycles, first ack 4 cycles after gate_en.
      add(4'hF, 1'b1, 4'h0, 2'd1, 4);
      add(4'hF, 1'b1, 4'hF, 2'd2, 1);
      // Grant changes with 1-cycle latency; drop all -> 8 idle cycles -> OFF.
      add(4'h1, 1'b1, 4'h1, 2'd2, 1);
      add(4'h3, 1'b1, 4'h3, 2'd2, 1);
      add(4'h0, 1'b1, 4'h0, 2'd3, 8);
      add(4'h0, 1'b0, 4'h0, 2'd0, 2);
      // One-cycle pulse from OFF: full wake, ON, idle, OFF, never an ack.
      add(4'h2, 1'b1, 4'h0, 2'd1, 1);
      add(4'h0, 1'b1, 4'h0, 2'd1, 3);
      add(4'h0, 1'b1, 4'h0, 2'd2, 1);
      add(4'h0, 1'b1, 4'h0, 2'd3, 8);
      add(4'h0, 1'b0, 4'h0, 2'd0, 1);
      // Return from IDLE_WAIT mid-window: no re-wake, ack one cycle later.
      add(4'h4, 1'b1, 4'h0, 2'd1, 4);
      add(4'h4, 1'b1, 4'h4, 2'd2, 1);
      add(4'h0, 1'b1, 4'h0, 2'd3, 6);
      add(4'h4, 1'b1, 4'h0, 2'd2, 1);
      add(4'h4, 1'b1, 4'h4, 2'd2, 1);
      // Request on the exact cycle the idle count expires keeps gate_en up.
      add(4'h0, 1'b1, 4'h0, 2'd3, 8);
      add(4'h8, 1'b1, 4'h0, 2'd2, 1);
      add(4'hC, 1'b1, 4'hC, 2'd2, 1);
      add(4'h0, 1'b1, 4'h0, 2'd3, 8);
      add(4'h0, 1'b0, 4'h0, 2'd0, 1);

      reset_n = 1'b1;
      for (int unsigned i = 0; i < tbl.size(); i++) begin
         req = tbl[i].req;
         sb.push_back(tbl[i]);
         @(negedge clock_input);
         if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check_all($sformatf("vec%0d", i), e.gate, e.ack, e.st, e.st[1]);
         end
      end
      check("scoreboard_drained", sb.size(), 32'd0);

      // Asynchronous reset in the middle of WAKE.
      req = 4'hF;
      repeat (2) @(negedge clock_input);
      check_all("pre_rst_wake", 1'b1, 4'h0, 2'd1, 1'b0);
      #2 reset_n = 1'b0;
      #1 check_all("rst_mid_wake", 1'b0, 4'h0, 2'd0, 1'b0);
      @(negedge clock_input);
      reset_n = 1'b1;

      // Asynchronous reset in the middle of ON.
      repeat (5) @(negedge clock_input);
      check_all("pre_rst_on", 1'b1, 4'hF, 2'd2, 1'b1);
      #2 reset_n = 1'b0;
      #1 check_all("rst_mid_on", 1'b0, 4'h0, 2'd0, 1'b0);
      req = 4'h0;
      @(negedge clock_input);
      reset_n = 1'b1;
      @(negedge clock_input);
      check_all("post_rst_idle", 1'b0, 4'h0, 2'd0, 1'b0);

`ifdef CLK_BUF_GATE_FORCE_ON_EN
      // force_on alone wakes the buffer and holds it on without any ack.
      force_on = 1'b1;
      @(negedge clock_input);
      check_all("force_wake", 1'b1, 4'h0, 2'd1, 1'b0);
      repeat (3) @(negedge clock_input);
      for (int unsigned i = 0; i < 16; i++) begin
         @(negedge clock_input);
         check_all($sformatf("force_hold%0d", i), 1'b1, 4'h0, 2'd2, 1'b1);
      end
      force_on = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         @(negedge clock_input);
         check_all($sformatf("force_idle%0d", i), 1'b1, 4'h0, 2'd3, 1'b1);
      end
      @(negedge clock_input);
      check_all("force_off", 1'b0, 4'h0, 2'd0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
